// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with burst lock driving a 4:1 mux select
// Captures the selected mux output into a single-entry valid/ready output register.
module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int SEL_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          in_valid,
    input  logic [3:0]          in_last,
    output logic [3:0]          in_ready,
    output logic [SEL_BITS-1:0] sel,
    input  logic [WIDTH-1:0]    mux_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data
);

    if (SEL_BITS != 2) begin : g_sel_bits_check
        $error("mux_rr_arbiter: SEL_BITS must be 2 for four channels");
    end

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [1:0] ptr;
    logic [1:0] lk;
    logic [1:0] win_idx;
    logic [1:0] scan_idx;
    logic       win_found;
    logic       load_en;
    logic       xfer;

    assign load_en = !out_valid || out_ready;
    assign xfer    = win_found && load_en;

    // Without a winner win_idx falls back to ptr (ARB) or lk (LOCK), so sel is always defined.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        scan_idx  = ptr;
        if (state == LOCK) begin
            win_idx   = lk;
            win_found = in_valid[lk];
        end else begin
            for (int i = 1; i <= 4; i++) begin
                scan_idx = ptr + 2'(i);
                if (!win_found && in_valid[scan_idx]) begin
                    win_found = 1'b1;
                    win_idx   = scan_idx;
                end
            end
        end
    end

    assign sel = win_idx;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:  if (xfer && !in_last[win_idx]) state_next = LOCK;
            LOCK: if (xfer && in_last[lk])       state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            ptr   <= 2'd3;
            lk    <= 2'd0;
        end else begin
            state <= state_next;
            if (xfer) begin
                ptr <= win_idx;
                if (state == ARB) begin
                    lk <= win_idx;
                end
            end
        end
    end

    // Output stage: load replaces the beat; a drain with nothing to load empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_last  <= in_last[win_idx];
            out_data  <= mux_data;
        end else if (load_en) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Upstream control stage for the 4-input select mux.
- Arbitrates four valid/ready source channels round-robin and drives the mux select.
- Captures the returned mux output into a single-entry registered output stage with a valid/ready handshake.
- Supports burst locking: once a channel wins, it keeps the grant until it delivers a beat with last asserted.

Parameters:
- WIDTH, 8, data width of each channel and of the mux output.
- SEL_BITS, 2, mux select width; must equal 2 (four channels). An elaboration-time assertion fails for any other value.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel request; bit i = channel i.
- in_last  input  4  per-channel end-of-burst flag; qualified by in_valid.
- in_ready  output  4  per-channel accept; one-hot or zero.
- sel  output  SEL_BITS  select driven to the mux; combinational.
- mux_data  input  WIDTH  mux output returned combinationally for the current sel.
- out_valid  output  1  output register holds a beat.
- out_last  output  1  last flag of the held beat.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  held beat.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_last=0, out_data=0.
  - Priority pointer ptr=3 (last-granted index), so channel 0 has first priority.
  - State=ARB, lock index lk=0.
- load_en = !out_valid || out_ready. Full throughput: one beat per cycle when downstream is always ready.
- Winner in ARB:
  - First index with in_valid set, scanning ptr+1, ptr+2, ptr+3, ptr, modulo 4.
  - No request means no winner.
- Winner in LOCK: lk, if in_valid[lk]; otherwise no winner. Other channels are never granted in LOCK.
- sel:
  - Equals the winner when one exists.
  - Otherwise ARB drives ptr and LOCK drives lk.
  - sel is never X, including during reset.
- in_ready[winner] = load_en; all other in_ready bits are 0. in_ready never depends on in_valid of other channels beyond winner selection.
- Transfer: when a winner exists and load_en is set, on the clock edge:
  - out_data <= mux_data; out_last <= in_last[winner]; out_valid <= 1; ptr <= winner.
- Drain: load_en set with no transfer clears out_valid to 0, because downstream took the beat and nothing replaced it.
- Hold: out_valid=1 with out_ready=0 keeps out_data, out_last and out_valid stable, and all in_ready bits are 0.
- State machine:
  - ARB -> LOCK: transfer with in_last[winner]=0; lk <= winner.
  - LOCK -> ARB: transfer with in_last[lk]=1.
  - All other cases hold state.
  - A single-beat burst (last=1 in ARB) stays in ARB.
- Fairness: after a burst ends, ptr=lk, so the burst owner has lowest priority next.
- Simultaneous drain and load: out_ready=1 and a transfer in the same cycle replaces the beat; out_valid stays 1 with no bubble.
- Reset mid-burst: state returns to ARB and ptr to 3, and the in-flight output beat is dropped.
- No combinational path from out_ready to out_valid. The only combinational path from out_ready is to in_ready.

Test Plan:
- Reset: assert rst mid-cycle -> out_valid=0, out_data=0 immediately; sel=3 with no requests; in_ready=0000.
- Round-robin: in_valid=1111, all last=1, out_ready=1 -> grant order 0,1,2,3,0; one beat per cycle; out_data matches mux_data for in0..in3 = 8'h10, 8'h20, 8'h30, 8'h40.
- Burst lock: ch1 sends 3 beats (last on 3rd) while ch0 and ch2 are valid -> sel stays 1 for 3 transfers; next grant goes to ch2, then ch0.
- Backpressure: out_ready=0 for 4 cycles with ch3 valid -> one beat captured, in_ready=0000 and out_data stable; releasing out_ready yields back-to-back beats with no bubble.
- Gap in lock: ch0 burst pauses (in_valid[0]=0) while ch1 is valid -> no grant to ch1, sel=0; resume ch0, last=1 -> then ch1 granted.
- Reset mid-burst: rst during ch2 burst beat 2 -> after release, ch0 and ch2 both valid -> ch0 wins (ptr=3).
